// File: rtl/ingress_cpl_router.sv
// Completion router: steers incoming completion TLPs to one of NUM_DST streams using a
// per-tag destination table filled at request time, and releases tags on their final completion.
module ingress_cpl_router #(
    parameter int DW        = 256,
    parameter int KW        = DW / 32,
    parameter int TAG_W     = 5,
    parameter int NUM_DST   = 4,
    parameter int DST_W     = $clog2(NUM_DST),
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tag_vld,
    input  logic [TAG_W-1:0]     tag,
    input  logic [DST_W-1:0]     tag_dst,
    input  logic                 cpl_valid,
    output logic                 cpl_rdy,
    input  logic [DW-1:0]        cpl_data,
    input  logic [KW-1:0]        cpl_keep,
    input  logic                 cpl_sop,
    input  logic                 cpl_eop,
    input  logic [TAG_W-1:0]     cpl_tag,
    input  logic                 cpl_final,
    output logic [NUM_DST-1:0]   m_tvalid,
    input  logic [NUM_DST-1:0]   m_tready,
    output logic [DW-1:0]        m_tdata,
    output logic [KW-1:0]        m_tkeep,
    output logic                 m_sop,
    output logic                 m_eop,
    output logic [TAG_W:0]       outstanding,
    output logic                 err_unexp,
    output logic                 err_dup,
    output logic [ERR_CNT_W-1:0] err_unexp_cnt,
    output logic [ERR_CNT_W-1:0] err_dup_cnt
);

    localparam int NUM_TAG = 2 ** TAG_W;
    localparam logic [DST_W:0] NUM_DST_EXT = (DST_W + 1)'(NUM_DST);

    // Handshake: a completion beat transfers on a clk edge where cpl_valid && cpl_rdy;
    // an output beat transfers on an edge where m_tvalid[i] && m_tready[i].
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // Per-packet context; state is kept here so it is visible as one named struct.
    typedef struct packed {
        state_e             state;
        logic [DST_W-1:0]   dst;
        logic               fin;
        logic [TAG_W-1:0]   tag;
    } pkt_ctx_t;

    pkt_ctx_t                     ctx_q, ctx_d;
    logic [NUM_TAG-1:0]           tbl_vld_q, tbl_vld_d;
    logic [NUM_TAG-1:0][DST_W-1:0] tbl_dst_q, tbl_dst_d;

    logic                 obuf_vld_q, obuf_vld_d;
    logic [DST_W-1:0]     obuf_dst_q, obuf_dst_d;
    logic [DW-1:0]        obuf_data_q, obuf_data_d;
    logic [KW-1:0]        obuf_keep_q, obuf_keep_d;
    logic                 obuf_sop_q, obuf_sop_d;
    logic                 obuf_eop_q, obuf_eop_d;

    logic [TAG_W:0]       outstanding_q, outstanding_d;
    logic                 unexp_q, unexp_d;
    logic                 dup_q, dup_d;
    logic [ERR_CNT_W-1:0] unexp_cnt_q, unexp_cnt_d;
    logic [ERR_CNT_W-1:0] dup_cnt_q, dup_cnt_d;

    logic                 obuf_free;
    logic                 acc;
    logic                 lkp_vld;
    logic [DST_W-1:0]     lkp_dst;
    logic                 lkp_hit;
    logic                 fwd_load;
    logic [DST_W-1:0]     fwd_dst;
    logic                 rel;
    logic [TAG_W-1:0]     rel_tag;
    logic                 inc;
    logic                 dec;

    always_comb begin
        lkp_vld = tbl_vld_q[cpl_tag];
        lkp_dst = tbl_dst_q[cpl_tag];
        lkp_hit = lkp_vld && ({1'b0, lkp_dst} < NUM_DST_EXT);
    end

    // Packet FSM and output slice.
    always_comb begin
        ctx_d       = ctx_q;
        obuf_vld_d  = obuf_vld_q;
        obuf_dst_d  = obuf_dst_q;
        obuf_data_d = obuf_data_q;
        obuf_keep_d = obuf_keep_q;
        obuf_sop_d  = obuf_sop_q;
        obuf_eop_d  = obuf_eop_q;
        fwd_load    = 1'b0;
        fwd_dst     = ctx_q.dst;
        rel         = 1'b0;
        rel_tag     = ctx_q.tag;
        unexp_d     = 1'b0;

        obuf_free = !obuf_vld_q || m_tready[obuf_dst_q];
        cpl_rdy   = (ctx_q.state == ST_DROP) ? 1'b1 : obuf_free;
        acc       = cpl_valid && cpl_rdy;

        if (obuf_vld_q && m_tready[obuf_dst_q]) begin
            obuf_vld_d = 1'b0;
        end

        case (ctx_q.state)
            ST_IDLE: begin
                // Non-sop beats seen while idle have no owner and are discarded.
                if (acc && cpl_sop) begin
                    if (lkp_hit) begin
                        fwd_load  = 1'b1;
                        fwd_dst   = lkp_dst;
                        ctx_d.dst = lkp_dst;
                        ctx_d.fin = cpl_final;
                        ctx_d.tag = cpl_tag;
                        if (cpl_eop) begin
                            rel     = cpl_final;
                            rel_tag = cpl_tag;
                        end else begin
                            ctx_d.state = ST_FWD;
                        end
                    end else begin
                        unexp_d = 1'b1;
                        if (!cpl_eop) begin
                            ctx_d.state = ST_DROP;
                        end
                    end
                end
            end
            ST_FWD: begin
                if (acc) begin
                    fwd_load = 1'b1;
                    if (cpl_eop) begin
                        rel         = ctx_q.fin;
                        ctx_d.state = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (acc && cpl_eop) begin
                    ctx_d.state = ST_IDLE;
                end
            end
            default: begin
                ctx_d.state = ST_IDLE;
            end
        endcase

        if (fwd_load) begin
            obuf_vld_d  = 1'b1;
            obuf_dst_d  = fwd_dst;
            obuf_data_d = cpl_data;
            obuf_keep_d = cpl_keep;
            // A sop flag arriving mid-packet is body data, so only the idle-state beat is a start.
            obuf_sop_d  = (ctx_q.state == ST_IDLE);
            obuf_eop_d  = cpl_eop;
        end
    end

    // Tag table, outstanding count and error tracking. Allocation is applied after
    // release so a same-cycle allocation of the releasing tag keeps the entry valid.
    always_comb begin
        tbl_vld_d = tbl_vld_q;
        tbl_dst_d = tbl_dst_q;
        if (rel) begin
            tbl_vld_d[rel_tag] = 1'b0;
        end
        if (tag_vld) begin
            tbl_vld_d[tag] = 1'b1;
            tbl_dst_d[tag] = tag_dst;
        end

        inc = tag_vld && !tbl_vld_q[tag];
        dec = rel && tbl_vld_q[rel_tag] && !(tag_vld && (tag == rel_tag));

        outstanding_d = outstanding_q;
        case ({inc, dec})
            2'b10:   outstanding_d = outstanding_q + (TAG_W + 1)'(1);
            2'b01:   outstanding_d = outstanding_q - (TAG_W + 1)'(1);
            default: outstanding_d = outstanding_q;
        endcase

        dup_d = tag_vld && tbl_vld_q[tag];

        unexp_cnt_d = unexp_cnt_q;
        if (unexp_d && (unexp_cnt_q != {ERR_CNT_W{1'b1}})) begin
            unexp_cnt_d = unexp_cnt_q + ERR_CNT_W'(1);
        end
        dup_cnt_d = dup_cnt_q;
        if (dup_d && (dup_cnt_q != {ERR_CNT_W{1'b1}})) begin
            dup_cnt_d = dup_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctx_q         <= '0;
            tbl_vld_q     <= '0;
            tbl_dst_q     <= '0;
            obuf_vld_q    <= 1'b0;
            obuf_dst_q    <= '0;
            obuf_data_q   <= '0;
            obuf_keep_q   <= '0;
            obuf_sop_q    <= 1'b0;
            obuf_eop_q    <= 1'b0;
            outstanding_q <= '0;
            unexp_q       <= 1'b0;
            dup_q         <= 1'b0;
            unexp_cnt_q   <= '0;
            dup_cnt_q     <= '0;
        end else begin
            ctx_q         <= ctx_d;
            tbl_vld_q     <= tbl_vld_d;
            tbl_dst_q     <= tbl_dst_d;
            obuf_vld_q    <= obuf_vld_d;
            obuf_dst_q    <= obuf_dst_d;
            obuf_data_q   <= obuf_data_d;
            obuf_keep_q   <= obuf_keep_d;
            obuf_sop_q    <= obuf_sop_d;
            obuf_eop_q    <= obuf_eop_d;
            outstanding_q <= outstanding_d;
            unexp_q       <= unexp_d;
            dup_q         <= dup_d;
            unexp_cnt_q   <= unexp_cnt_d;
            dup_cnt_q     <= dup_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            m_tvalid[i] = obuf_vld_q && (obuf_dst_q == DST_W'(i));
        end
    end

    assign m_tdata       = obuf_data_q;
    assign m_tkeep       = obuf_keep_q;
    assign m_sop         = obuf_sop_q;
    assign m_eop         = obuf_eop_q;
    assign outstanding   = outstanding_q;
    assign err_unexp     = unexp_q;
    assign err_dup       = dup_q;
    assign err_unexp_cnt = unexp_cnt_q;
    assign err_dup_cnt   = dup_cnt_q;

endmodule

// File: tb/tb_ingress_cpl_router.sv
// Directed bench for ingress_cpl_router: routing, drop of unknown tags, back-pressure,
// duplicate allocation, same-cycle alloc/release and mid-packet reset.
module tb_ingress_cpl_router;

    localparam int DW        = 256;
    localparam int KW        = 8;
    localparam int TAG_W     = 5;
    localparam int NUM_DST   = 4;
    localparam int DST_W     = 2;
    localparam int ERR_CNT_W = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 tag_vld;
    logic [TAG_W-1:0]     tag;
    logic [DST_W-1:0]     tag_dst;
    logic                 cpl_valid;
    logic                 cpl_rdy;
    logic [DW-1:0]        cpl_data;
    logic [KW-1:0]        cpl_keep;
    logic                 cpl_sop;
    logic                 cpl_eop;
    logic [TAG_W-1:0]     cpl_tag;
    logic                 cpl_final;
    logic [NUM_DST-1:0]   m_tvalid;
    logic [NUM_DST-1:0]   m_tready;
    logic [DW-1:0]        m_tdata;
    logic [KW-1:0]        m_tkeep;
    logic                 m_sop;
    logic                 m_eop;
    logic [TAG_W:0]       outstanding;
    logic                 err_unexp;
    logic                 err_dup;
    logic [ERR_CNT_W-1:0] err_unexp_cnt;
    logic [ERR_CNT_W-1:0] err_dup_cnt;

    int checks = 0;
    int errors = 0;
    int dst_cnt[NUM_DST];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    ingress_cpl_router #(
        .DW(DW), .KW(KW), .TAG_W(TAG_W), .NUM_DST(NUM_DST), .DST_W(DST_W), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tag_vld(tag_vld), .tag(tag), .tag_dst(tag_dst),
        .cpl_valid(cpl_valid), .cpl_rdy(cpl_rdy), .cpl_data(cpl_data), .cpl_keep(cpl_keep),
        .cpl_sop(cpl_sop), .cpl_eop(cpl_eop), .cpl_tag(cpl_tag), .cpl_final(cpl_final),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_sop(m_sop), .m_eop(m_eop), .outstanding(outstanding),
        .err_unexp(err_unexp), .err_dup(err_dup),
        .err_unexp_cnt(err_unexp_cnt), .err_dup_cnt(err_dup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: counts delivered beats per destination and records their data.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_DST; i++) begin
                if (m_tvalid[i] && m_tready[i]) begin
                    dst_cnt[i] = dst_cnt[i] + 1;
                    got_q.push_back(m_tdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int n);
        return {8{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic sop, input logic eop,
                         input logic [TAG_W-1:0] t, input logic fin);
        cpl_valid = 1'b1;
        cpl_data  = d;
        cpl_keep  = '1;
        cpl_sop   = sop;
        cpl_eop   = eop;
        cpl_tag   = t;
        cpl_final = fin;
    endtask

    task automatic idle_in();
        cpl_valid = 1'b0;
        cpl_sop   = 1'b0;
        cpl_eop   = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop,
                        input logic [TAG_W-1:0] t, input logic fin);
        int k;
        drive(d, sop, eop, t, fin);
        #1;
        k = 0;
        while (!cpl_rdy && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("accept_timeout", DW'(k < 50), DW'(1));
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic alloc(input logic [TAG_W-1:0] t, input logic [DST_W-1:0] d);
        tag_vld = 1'b1;
        tag     = t;
        tag_dst = d;
        step();
        tag_vld = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        tag_vld   = 1'b0;
        tag       = '0;
        tag_dst   = '0;
        cpl_data  = '0;
        cpl_keep  = '0;
        cpl_tag   = '0;
        cpl_final = 1'b0;
        m_tready  = '1;
        idle_in();
        step();
        step();

        // Reset state
        chk("rst_tvalid", DW'(m_tvalid), DW'(0));
        chk("rst_outstanding", DW'(outstanding), DW'(0));
        chk("rst_tdata", m_tdata, '0);
        chk("rst_unexp_cnt", DW'(err_unexp_cnt), DW'(0));
        chk("rst_dup_cnt", DW'(err_dup_cnt), DW'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", DW'(cpl_rdy), DW'(1));

        // 3-beat completion on tag 3 -> dst 2
        alloc(5'd3, 2'd2);
        chk("t1_outstanding_alloc", DW'(outstanding), DW'(1));
        send(pat(10), 1'b1, 1'b0, 5'd3, 1'b1);
        chk("t1_b0_tvalid", DW'(m_tvalid), DW'(4'b0100));
        chk("t1_b0_sop", DW'(m_sop), DW'(1));
        chk("t1_b0_data", m_tdata, pat(10));
        send(pat(11), 1'b0, 1'b0, 5'd3, 1'b0);
        chk("t1_b1_tvalid", DW'(m_tvalid), DW'(4'b0100));
        chk("t1_b1_sop", DW'(m_sop), DW'(0));
        chk("t1_b1_outstanding", DW'(outstanding), DW'(1));
        send(pat(12), 1'b0, 1'b1, 5'd3, 1'b0);
        chk("t1_b2_tvalid", DW'(m_tvalid), DW'(4'b0100));
        chk("t1_b2_eop", DW'(m_eop), DW'(1));
        chk("t1_b2_outstanding", DW'(outstanding), DW'(0));
        step();
        chk("t1_idle_tvalid", DW'(m_tvalid), DW'(0));
        chk("t1_dst2_beats", DW'(dst_cnt[2]), DW'(3));

        // Non-final then final single-beat completions on tag 5 -> dst 1
        alloc(5'd5, 2'd1);
        chk("t2_outstanding_alloc", DW'(outstanding), DW'(1));
        send(pat(20), 1'b1, 1'b1, 5'd5, 1'b0);
        chk("t2_nf_tvalid", DW'(m_tvalid), DW'(4'b0010));
        chk("t2_nf_outstanding", DW'(outstanding), DW'(1));
        send(pat(21), 1'b1, 1'b1, 5'd5, 1'b1);
        chk("t2_f_tvalid", DW'(m_tvalid), DW'(4'b0010));
        chk("t2_f_outstanding", DW'(outstanding), DW'(0));
        chk("t2_unexp", DW'(err_unexp), DW'(0));
        step();
        chk("t2_dst1_beats", DW'(dst_cnt[1]), DW'(2));

        // Unallocated tag 7, two beats: dropped and flagged once
        drive(pat(30), 1'b1, 1'b0, 5'd7, 1'b1);
        #1;
        chk("t3_b0_rdy", DW'(cpl_rdy), DW'(1));
        step();
        idle_in();
        chk("t3_b0_unexp", DW'(err_unexp), DW'(1));
        chk("t3_b0_tvalid", DW'(m_tvalid), DW'(0));
        chk("t3_b0_cnt", DW'(err_unexp_cnt), DW'(1));
        drive(pat(31), 1'b0, 1'b1, 5'd7, 1'b0);
        #1;
        chk("t3_b1_rdy", DW'(cpl_rdy), DW'(1));
        step();
        idle_in();
        chk("t3_b1_unexp", DW'(err_unexp), DW'(0));
        chk("t3_b1_tvalid", DW'(m_tvalid), DW'(0));
        chk("t3_b1_cnt", DW'(err_unexp_cnt), DW'(1));

        // Back-pressure on dst 0 for 4 cycles mid-packet
        alloc(5'd2, 2'd0);
        got_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(pat(40 + i));
        m_tready = 4'b1110;
        send(pat(40), 1'b1, 1'b0, 5'd2, 1'b1);
        chk("t4_b0_tvalid", DW'(m_tvalid), DW'(4'b0001));
        drive(pat(41), 1'b0, 1'b0, 5'd2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t4_stall_rdy", DW'(cpl_rdy), DW'(0));
            chk("t4_stall_data", m_tdata, pat(40));
            step();
        end
        m_tready = '1;
        #1;
        chk("t4_resume_rdy", DW'(cpl_rdy), DW'(1));
        step();
        idle_in();
        for (int i = 2; i < 6; i++) begin
            send(pat(40 + i), 1'b0, (i == 5), 5'd2, 1'b0);
        end
        step();
        step();
        chk("t4_dst0_beats", DW'(dst_cnt[0]), DW'(6));
        chk("t4_got_size", DW'(got_q.size()), DW'(6));
        for (int i = 0; i < 6; i++) begin
            chk("t4_data_order", (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        end
        chk("t4_outstanding", DW'(outstanding), DW'(0));

        // Duplicate allocation of tag 9, then allocation racing its final eop
        alloc(5'd9, 2'd3);
        chk("t5_dup0", DW'(err_dup), DW'(0));
        chk("t5_out0", DW'(outstanding), DW'(1));
        alloc(5'd9, 2'd3);
        chk("t5_dup1", DW'(err_dup), DW'(1));
        chk("t5_dup_cnt1", DW'(err_dup_cnt), DW'(1));
        chk("t5_out1", DW'(outstanding), DW'(1));
        step();
        chk("t5_dup_clear", DW'(err_dup), DW'(0));
        tag_vld = 1'b1;
        tag     = 5'd9;
        tag_dst = 2'd3;
        drive(pat(50), 1'b1, 1'b1, 5'd9, 1'b1);
        #1;
        chk("t5_race_rdy", DW'(cpl_rdy), DW'(1));
        step();
        tag_vld = 1'b0;
        idle_in();
        chk("t5_race_tvalid", DW'(m_tvalid), DW'(4'b1000));
        chk("t5_race_out", DW'(outstanding), DW'(1));
        chk("t5_race_dup_cnt", DW'(err_dup_cnt), DW'(2));
        send(pat(51), 1'b1, 1'b1, 5'd9, 1'b0);
        chk("t5_still_valid_tvalid", DW'(m_tvalid), DW'(4'b1000));
        chk("t5_still_valid_unexp", DW'(err_unexp), DW'(0));
        chk("t5_still_valid_out", DW'(outstanding), DW'(1));

        // Reset in the middle of a forwarded packet
        send(pat(60), 1'b1, 1'b0, 5'd9, 1'b0);
        chk("t6_fwd_tvalid", DW'(m_tvalid), DW'(4'b1000));
        drive(pat(61), 1'b0, 1'b0, 5'd9, 1'b0);
        rst_n = 1'b0;
        step();
        chk("t6_rst_tvalid", DW'(m_tvalid), DW'(0));
        chk("t6_rst_sop", DW'(m_sop), DW'(0));
        chk("t6_rst_eop", DW'(m_eop), DW'(0));
        chk("t6_rst_tdata", m_tdata, '0);
        chk("t6_rst_tkeep", DW'(m_tkeep), DW'(0));
        chk("t6_rst_out", DW'(outstanding), DW'(0));
        chk("t6_rst_unexp_cnt", DW'(err_unexp_cnt), DW'(0));
        chk("t6_rst_dup_cnt", DW'(err_dup_cnt), DW'(0));
        rst_n = 1'b1;
        idle_in();
        step();
        send(pat(62), 1'b1, 1'b1, 5'd9, 1'b1);
        chk("t6_post_unexp", DW'(err_unexp), DW'(1));
        chk("t6_post_tvalid", DW'(m_tvalid), DW'(0));
        chk("t6_post_unexp_cnt", DW'(err_unexp_cnt), DW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ingress_cpl_router.md
Name: ingress_cpl_router

Overview:
Parametrised completion router for the ingress path. It records a destination ID per outstanding non-posted tag when the request is issued. Incoming completion TLPs are looked up by tag and steered to one of NUM_DST output streams. The tag is released on the final completion, unexpected or duplicate tags are flagged, and an outstanding-tag count is kept for egress throttling.

Parameters:
DW, 256, completion data width in bits (multiple of 32)
KW, DW/32, keep width, one bit per dword
TAG_W, 5, tag width; table depth NUM_TAG = 2**TAG_W
NUM_DST, 4, number of output destinations (2..16)
DST_W, $clog2(NUM_DST), destination index width
ERR_CNT_W, 16, width of error counters

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tag_vld  in  1  tag allocation strobe from request egress
tag  in  TAG_W  allocated tag
tag_dst  in  DST_W  destination for that tag
cpl_valid  in  1  completion beat valid
cpl_rdy  out  1  completion beat accepted when cpl_valid&&cpl_rdy
cpl_data  in  DW  completion payload
cpl_keep  in  KW  dword keep
cpl_sop  in  1  first beat of TLP
cpl_eop  in  1  last beat of TLP
cpl_tag  in  TAG_W  TLP tag, valid on sop beat
cpl_final  in  1  last completion for this tag (byte count == length), valid on sop beat
m_tvalid  out  NUM_DST  one-hot beat valid per destination
m_tready  in  NUM_DST  per-destination ready
m_tdata  out  DW  shared data
m_tkeep  out  KW  shared keep
m_sop  out  1  shared sop
m_eop  out  1  shared eop
outstanding  out  TAG_W+1  number of valid table entries
err_unexp  out  1  one-cycle pulse: completion for an invalid tag or a destination >= NUM_DST
err_dup  out  1  one-cycle pulse: allocation of an already-valid tag
err_unexp_cnt  out  ERR_CNT_W  saturating count of err_unexp
err_dup_cnt  out  ERR_CNT_W  saturating count of err_dup

Behaviour:
- Reset (rst_n=0 at a clk edge): all table valid bits 0. outstanding, m_tvalid, m_sop, m_eop, err_* and both counters = 0. m_tdata/m_tkeep = 0. Reset mid-packet discards the packet and all state.
- Tag table: flop array of NUM_TAG entries {valid, dst}. tag_vld writes {1, tag_dst} at the next edge. If the entry is already valid: overwrite, pulse err_dup.
- Packet FSM, states IDLE / FWD / DROP:
  - IDLE: on an accepted sop beat, look up table[cpl_tag] combinationally.
    - valid && dst < NUM_DST: latch dst and the final flag, forward the beat, go to FWD.
    - otherwise: pulse err_unexp, drop the beat, go to DROP.
  - A beat with sop&&eop completes in the same cycle and the FSM stays in IDLE.
  - FWD: forward beats to the latched dst; on eop return to IDLE.
  - DROP: cpl_rdy=1 and beats are discarded; on eop return to IDLE.
  - A sop arriving in FWD/DROP is ignored as sop and treated as a body beat.
- Output stage: single register slice, latency 1 cycle from acceptance to m_tvalid.
  - cpl_rdy = !obuf_vld || m_tready[obuf_dst] in IDLE/FWD, giving full throughput.
  - m_tvalid = obuf_vld one-hot at obuf_dst. Data, keep, sop and eop stay stable while valid && !ready.
- Tag release: when the eop beat of a forwarded TLP with latched final=1 is accepted, clear table[tag] valid at the next edge. Dropped TLPs never release.
- Same-cycle allocation and release of the same tag: allocation wins, the entry stays valid with the new dst, and outstanding is unchanged net.
- outstanding: +1 for each allocation of an invalid entry, -1 for each release. Both in one cycle on different tags gives net 0. Never wraps: the max is NUM_TAG, which fits in TAG_W+1 bits.
- Counters: +1 per corresponding pulse, saturating at all-ones.
- cpl_keep is passed through unmodified. Byte-count checking is the upstream's responsibility.

Test Plan:
- Allocate tag 3 -> dst 2. Send a 3-beat completion, tag 3, final=1, all m_tready=1 -> m_tvalid=4'b0100 for 3 consecutive cycles starting 1 cycle after the first accept. sop on beat 0, eop on beat 2. outstanding goes 1 -> 0 the cycle after eop accept.
- Allocate tag 5 -> dst 1. Send final=0 then final=1 single-beat completions -> both routed to dst 1. Entry stays valid after the first and is cleared after the second. outstanding = 1 then 0.
- Completion on unallocated tag 7, 2 beats -> no m_tvalid, cpl_rdy=1 both beats, err_unexp pulses once, err_unexp_cnt=1.
- dst 0 m_tready held 0 for 4 cycles mid-packet -> cpl_rdy=0, m_tdata stable, no beats lost. Total beats out equals beats in.
- Allocate tag 9 twice -> err_dup pulses once, outstanding=1. Allocate tag 9 in the same cycle as its final eop -> entry remains valid, outstanding stays 1.
- Assert rst_n=0 during a FWD packet -> all outputs 0 next cycle, outstanding=0, a following tag-9 completion is flagged err_unexp.
